// File: rtl/vi53_sound.sv
// Sound mixer: synchronises and glitch-filters five 1-bit sources, mixes them
// into a weighted PCM level and drives a first-order sigma-delta DAC bit.
module vi53_sound #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned PCM_W    = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic             out0_i,
  input  logic             out1_i,
  input  logic             out2_i,
  input  logic             beep_i,
  input  logic             tape_i,
  input  logic             cfg_we_i,
  input  logic [7:0]       cfg_d_i,
  output logic [7:0]       cfg_q_o,
  output logic [PCM_W-1:0] pcm_o,
  output logic             dac_o,
  output logic             active_o
);

  localparam int unsigned NumSrc = 5;

  // Source order: {tape, beep, out2, out1, out0}
  logic [NumSrc-1:0]      src;
  logic [NumSrc-1:0]      sync1_q, sync2_q;
  logic [NumSrc-1:0]      filt_q, filt_d;
  logic [NumSrc-1:0][3:0] cnt_q, cnt_d;
  logic [6:0]             cfg_q, cfg_d;
  logic [NumSrc-1:0]      en, hit;
  logic [8:0]             sum;
  logic [9:0]             level;
  logic [PCM_W-1:0]       pcm_q, pcm_d;
  logic                   active_q, active_d;
  logic [10:0]            acc_q, acc_d;
  logic                   dac_q;

  assign src = {tape_i, beep_i, out2_i, out1_i, out0_i};

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (ce_i) begin
      for (int i = 0; i < NumSrc; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          if (cnt_d[i] == 4'(FILT_LEN)) begin
            filt_d[i] = sync2_q[i];
            cnt_d[i]  = 4'd0;
          end
        end
      end
    end
  end

  assign cfg_d = cfg_we_i ? cfg_d_i[6:0] : cfg_q;

  assign en  = {cfg_q[4], cfg_q[3], cfg_q[2:0]};
  assign hit = filt_q & en;

  always_comb begin
    sum = 9'd0;
    if (hit[0]) sum = sum + 9'd64;
    if (hit[1]) sum = sum + 9'd64;
    if (hit[2]) sum = sum + 9'd64;
    if (hit[3]) sum = sum + 9'd128;
    if (hit[4]) sum = sum + 9'd32;
  end

  always_comb begin
    level = 10'd0;
    unique case (cfg_q[6:5])
      2'b00: level = 10'd0;
      2'b01: level = {2'b00, sum[8:1]};
      2'b10: level = {1'b0, sum};
      2'b11: level = {sum, 1'b0};
      default: level = 10'd0;
    endcase
  end

  assign pcm_d    = PCM_W'(level);
  assign active_d = |hit;

  // Drop the previous carry, then add: dac is the carry-out of the new sum.
  assign acc_d = {1'b0, acc_q[9:0]} + 11'(pcm_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      cfg_q    <= 7'h5F;
      pcm_q    <= '0;
      active_q <= 1'b0;
      acc_q    <= '0;
      dac_q    <= 1'b0;
    end else begin
      sync1_q  <= src;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      pcm_q    <= pcm_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      dac_q    <= acc_d[10];
    end
  end

  assign cfg_q_o  = {1'b0, cfg_q};
  assign pcm_o    = pcm_q;
  assign dac_o    = dac_q;
  assign active_o = active_q;

endmodule

// File: doc/vi53_sound.md
VI53_SOUND -- requirements
Module: vi53_sound

Interface
REQ-001 Parameter FILT_LEN, default 4: consecutive ce samples of one synced value needed before a filtered input changes (legal 1..15).
REQ-002 Parameter PCM_W, default 10: width of pcm output.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ce  input  1  filter sample strobe, one clk wide, any rate up to every cycle.
REQ-006 out0, out1, out2  input  1 each  timer channel outputs, asynchronous to clk.
REQ-007 beep  input  1  system speaker bit, asynchronous.
REQ-008 tape  input  1  tape-out bit, asynchronous.
REQ-009 cfg_we  input  1  config write strobe; level-sampled every clk.
REQ-010 cfg_d  input  8  config data: [2:0] channel mask, [3] beep enable, [4] tape enable, [6:5] volume, [7] ignored.
REQ-011 cfg_q  output  8  current config register, bit 7 reads 0.
REQ-012 pcm  output  PCM_W  unsigned mixed level, registered.
REQ-013 dac  output  1  first-order sigma-delta bitstream, registered.
REQ-014 active  output  1  registered; high when any enabled filtered source is 1.

Function
REQ-015 Each of the 5 inputs SHALL pass through a 2-flop synchronizer clocked by clk.
REQ-016 Per input, a 4-bit stability counter and a filtered bit SHALL update only on ce=1.
REQ-017 On ce, if synced value equals filtered bit, counter SHALL clear to 0.
REQ-018 On ce, if synced value differs, counter SHALL increment; when incremented value reaches FILT_LEN, filtered bit SHALL take the synced value and counter SHALL clear, same edge.
REQ-019 With FILT_LEN=1, a change SHALL be accepted on the first ce after it is synced.
REQ-020 A change that reverts before FILT_LEN samples SHALL clear the counter and never reach the filtered bit.
REQ-021 Weights: out0/out1/out2 = 64 each, beep = 128, tape = 32; a source contributes its weight only when filtered bit = 1 and its enable bit = 1.
REQ-022 Raw sum SHALL be 9 bits (max 352); volume 00 -> 0, 01 -> sum>>1 (truncate), 10 -> sum, 11 -> sum<<1 (max 704).
REQ-023 pcm and active SHALL be registered every clk from current filtered bits and cfg; latency filtered change -> pcm = 1 clk.
REQ-024 A cfg_we write SHALL load cfg on that edge; pcm reflects new cfg 1 clk later.
REQ-025 cfg_we and ce on the same edge SHALL both take effect independently.
REQ-026 Sigma-delta: 11-bit accumulator acc; every clk acc <= {1'b0, acc[9:0]} + pcm; dac <= carry bit acc[10] of the new sum.
REQ-027 Over any 1024 consecutive clks with constant pcm = P, dac SHALL be high exactly P times.
REQ-028 pcm = 0 SHALL hold dac low; no ce SHALL freeze filtered bits but not the modulator.

Reset
REQ-029 On reset=1 at a clk edge: synchronizers, counters, filtered bits, pcm, acc, dac, active SHALL clear to 0; cfg SHALL load 8'h5F (all enabled, volume 10).
REQ-030 Reset SHALL override cfg_we and ce on the same edge; reset mid-filter discards the pending count.
REQ-031 cfg_q SHALL read 8'h5F on the cycle after reset.

Verification
REQ-032 Reset, ce every clk, out0 0->1 held -> pcm=64 at clk 2(sync)+4(filter)+1 = 7 edges after change; active=1.
REQ-033 FILT_LEN=4, ce every clk, beep high for 3 clks then low -> pcm stays 0, counter returns 0.
REQ-034 All inputs high, cfg_d=8'h7F -> pcm=704; cfg_d=8'h3F -> pcm=176; cfg_d=8'h1F -> pcm=0, dac constant 0.
REQ-035 cfg_d=8'h41 (out0 only, vol 10), out0=1 filtered -> over 1024 clks dac high 64 times; dac period 16.
REQ-036 Reset asserted during filter count with ce and cfg_we=1, cfg_d=8'h00 -> cfg_q=8'h5F, pcm=0, dac=0 next cycle.
